// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared opcodes, default sizes and helpers for the ALU reservation station
package alu_rs_pkg;

  localparam int RS_SIZE_DEFAULT = 4;
  localparam int ROB_W_DEFAULT   = 4;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SLL   = 5'd2,
    OP_SLT   = 5'd3,
    OP_SLTU  = 5'd4,
    OP_XOR   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_OR    = 5'd8,
    OP_AND   = 5'd9,
    OP_BEQ   = 5'd10,
    OP_BNE   = 5'd11,
    OP_BLT   = 5'd12,
    OP_BGE   = 5'd13,
    OP_BLTU  = 5'd14,
    OP_BGEU  = 5'd15,
    OP_JAL   = 5'd16,
    OP_JALR  = 5'd17,
    OP_LUI   = 5'd18,
    OP_AUIPC = 5'd19
  } alu_op_e;

  // Size of the instruction in bytes, which is the distance to the link address.
  function automatic logic [31:0] link_incr(input logic inst_len);
    return inst_len ? 32'd4 : 32'd2;
  endfunction

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational integer ALU with branch compare and JALR target generation
module ALU
  import alu_rs_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] addr,
  input  logic [4:0]  alu_op,
  input  logic        inst_length,
  output logic [31:0] result,
  output logic        zero,
  output logic        jalr_done,
  output logic [31:0] jalr_addr
);

  logic        taken;
  logic        is_branch;
  logic [31:0] link;

  assign link = addr + link_incr(inst_length);

  // Compute result, branch outcome and jump target; zero means "not taken" for branches.
  always_comb begin
    result    = 32'd0;
    taken     = 1'b0;
    is_branch = 1'b0;
    jalr_done = 1'b0;
    jalr_addr = 32'd0;
    case (alu_op)
      OP_ADD:   result = op1 + op2;
      OP_SUB:   result = op1 - op2;
      OP_SLL:   result = op1 << op2[4:0];
      OP_SLT:   result = {31'd0, $signed(op1) < $signed(op2)};
      OP_SLTU:  result = {31'd0, op1 < op2};
      OP_XOR:   result = op1 ^ op2;
      OP_SRL:   result = op1 >> op2[4:0];
      OP_SRA:   result = $unsigned($signed(op1) >>> op2[4:0]);
      OP_OR:    result = op1 | op2;
      OP_AND:   result = op1 & op2;
      OP_BEQ:   begin is_branch = 1'b1; taken = (op1 == op2); end
      OP_BNE:   begin is_branch = 1'b1; taken = (op1 != op2); end
      OP_BLT:   begin is_branch = 1'b1; taken = ($signed(op1) < $signed(op2)); end
      OP_BGE:   begin is_branch = 1'b1; taken = ($signed(op1) >= $signed(op2)); end
      OP_BLTU:  begin is_branch = 1'b1; taken = (op1 < op2); end
      OP_BGEU:  begin is_branch = 1'b1; taken = (op1 >= op2); end
      OP_JAL:   result = link;
      OP_JALR:  begin
        result    = link;
        jalr_done = 1'b1;
        jalr_addr = (op1 + op2) & ~32'd1;
      end
      OP_LUI:   result = op2;
      OP_AUIPC: result = addr + op2;
      default:  result = 32'd0;
    endcase
    zero = is_branch ? ~taken : (result == 32'd0);
  end

endmodule

// File: rtl/alu_rs_pick.sv
// rtl/alu_rs_pick.sv - rotating-priority picker over the ready vector
module alu_rs_pick #(
  parameter int RS_SIZE = 4,
  parameter int IDX_W   = 2
) (
  input  logic [RS_SIZE-1:0] ready_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the ready entry closest to rr_ptr wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = '0;
    for (int k = RS_SIZE - 1; k >= 0; k--) begin
      idx = rr_ptr_i + IDX_W'(k);
      if (ready_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: issue, CDB wakeup, rotating select, registered result
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  parameter int ROB_W   = ROB_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             issue_valid,
  input  logic [4:0]       issue_op,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic             issue_rj,
  input  logic             issue_rk,
  input  logic [31:0]      issue_addr,
  input  logic             issue_len,
  input  logic [ROB_W-1:0] issue_dest,
  output logic             rs_full,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             out_valid,
  output logic [ROB_W-1:0] out_tag,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_jalr_done,
  output logic [31:0]      out_jalr_addr
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] rj_q, rj_d;
  logic [RS_SIZE-1:0] rk_q, rk_d;
  logic [RS_SIZE-1:0] len_q, len_d;
  logic [4:0]         op_q   [RS_SIZE];
  logic [4:0]         op_d   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vj_d   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];
  logic [31:0]        vk_d   [RS_SIZE];
  logic [31:0]        addr_q [RS_SIZE];
  logic [31:0]        addr_d [RS_SIZE];
  logic [ROB_W-1:0]   qj_q   [RS_SIZE];
  logic [ROB_W-1:0]   qj_d   [RS_SIZE];
  logic [ROB_W-1:0]   qk_q   [RS_SIZE];
  logic [ROB_W-1:0]   qk_d   [RS_SIZE];
  logic [ROB_W-1:0]   dest_q [RS_SIZE];
  logic [ROB_W-1:0]   dest_d [RS_SIZE];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Result register
  logic               out_valid_q, out_valid_d;
  logic [ROB_W-1:0]   out_tag_q, out_tag_d;
  logic [31:0]        out_result_q, out_result_d;
  logic               out_zero_q, out_zero_d;
  logic               out_jalr_done_q, out_jalr_done_d;
  logic [31:0]        out_jalr_addr_q, out_jalr_addr_d;

  // Select / issue helpers
  logic [RS_SIZE-1:0] ready_vec;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               issue_fire;
  logic               fwd_j, fwd_k;
  logic               dispatch;

  logic [31:0]        alu_result;
  logic               alu_zero;
  logic               alu_jalr_done;
  logic [31:0]        alu_jalr_addr;

  assign ready_vec  = busy_q & rj_q & rk_q;
  assign rs_full    = &busy_q;
  assign issue_fire = issue_valid & ~rs_full;
  assign fwd_j      = cdb_valid & ~issue_rj & (cdb_tag == issue_qj);
  assign fwd_k      = cdb_valid & ~issue_rk & (cdb_tag == issue_qk);
  assign dispatch   = grant_valid & ~flush_in;

  alu_rs_pick #(
    .RS_SIZE (RS_SIZE),
    .IDX_W   (IDX_W)
  ) u_pick (
    .ready_i       (ready_vec),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  ALU u_alu (
    .op1         (vj_q[grant_idx]),
    .op2         (vk_q[grant_idx]),
    .addr        (addr_q[grant_idx]),
    .alu_op      (op_q[grant_idx]),
    .inst_length (len_q[grant_idx]),
    .result      (alu_result),
    .zero        (alu_zero),
    .jalr_done   (alu_jalr_done),
    .jalr_addr   (alu_jalr_addr)
  );

  // Lowest-index free entry, judged on registered busy bits so a slot freed by dispatch waits a cycle.
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Entry next state: flush wins; otherwise wakeup, dispatch free and issue write.
  always_comb begin
    busy_d   = busy_q;
    rj_d     = rj_q;
    rk_d     = rk_q;
    len_d    = len_q;
    op_d     = op_q;
    vj_d     = vj_q;
    vk_d     = vk_q;
    addr_d   = addr_q;
    qj_d     = qj_q;
    qk_d     = qk_q;
    dest_d   = dest_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_in) begin
      busy_d   = '0;
      rr_ptr_d = '0;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && !rj_q[i] && (qj_q[i] == cdb_tag)) begin
            rj_d[i] = 1'b1;
            vj_d[i] = cdb_value;
          end
          if (busy_q[i] && !rk_q[i] && (qk_q[i] == cdb_tag)) begin
            rk_d[i] = 1'b1;
            vk_d[i] = cdb_value;
          end
        end
      end
      if (grant_valid) begin
        busy_d[grant_idx] = 1'b0;
        rr_ptr_d          = grant_idx + IDX_W'(1);
      end
      if (issue_fire) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = issue_op;
        vj_d[free_idx]   = fwd_j ? cdb_value : issue_vj;
        vk_d[free_idx]   = fwd_k ? cdb_value : issue_vk;
        rj_d[free_idx]   = issue_rj | fwd_j;
        rk_d[free_idx]   = issue_rk | fwd_k;
        qj_d[free_idx]   = issue_qj;
        qk_d[free_idx]   = issue_qk;
        addr_d[free_idx] = issue_addr;
        len_d[free_idx]  = issue_len;
        dest_d[free_idx] = issue_dest;
      end
    end
  end

  // Result register loads on dispatch; payload holds otherwise so only out_valid drops.
  always_comb begin
    out_valid_d     = dispatch;
    out_tag_d       = out_tag_q;
    out_result_d    = out_result_q;
    out_zero_d      = out_zero_q;
    out_jalr_done_d = out_jalr_done_q;
    out_jalr_addr_d = out_jalr_addr_q;
    if (dispatch) begin
      out_tag_d       = dest_q[grant_idx];
      out_result_d    = alu_result;
      out_zero_d      = alu_zero;
      out_jalr_done_d = alu_jalr_done;
      out_jalr_addr_d = alu_jalr_addr;
    end
  end

  // State register; rdy_in low freezes everything, dropping that cycle's issue and CDB.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q          <= '0;
      rj_q            <= '0;
      rk_q            <= '0;
      len_q           <= '0;
      rr_ptr_q        <= '0;
      out_valid_q     <= 1'b0;
      out_tag_q       <= '0;
      out_result_q    <= '0;
      out_zero_q      <= 1'b0;
      out_jalr_done_q <= 1'b0;
      out_jalr_addr_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        addr_q[i] <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q          <= busy_d;
      rj_q            <= rj_d;
      rk_q            <= rk_d;
      len_q           <= len_d;
      rr_ptr_q        <= rr_ptr_d;
      op_q            <= op_d;
      vj_q            <= vj_d;
      vk_q            <= vk_d;
      addr_q          <= addr_d;
      qj_q            <= qj_d;
      qk_q            <= qk_d;
      dest_q          <= dest_d;
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_result_q    <= out_result_d;
      out_zero_q      <= out_zero_d;
      out_jalr_done_q <= out_jalr_done_d;
      out_jalr_addr_q <= out_jalr_addr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_tag       = out_tag_q;
  assign out_result    = out_result_q;
  assign out_zero      = out_zero_q;
  assign out_jalr_done = out_jalr_done_q;
  assign out_jalr_addr = out_jalr_addr_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed self-checking bench for alu_rs
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        issue_valid;
  logic [4:0]  issue_op;
  logic [31:0] issue_vj, issue_vk, issue_addr;
  logic [3:0]  issue_qj, issue_qk, issue_dest;
  logic        issue_rj, issue_rk, issue_len;
  logic        rs_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_jalr_done;
  logic [31:0] out_jalr_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_rs #(.RS_SIZE(4), .ROB_W(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .issue_valid   (issue_valid),
    .issue_op      (issue_op),
    .issue_vj      (issue_vj),
    .issue_vk      (issue_vk),
    .issue_qj      (issue_qj),
    .issue_qk      (issue_qk),
    .issue_rj      (issue_rj),
    .issue_rk      (issue_rk),
    .issue_addr    (issue_addr),
    .issue_len     (issue_len),
    .issue_dest    (issue_dest),
    .rs_full       (rs_full),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .out_valid     (out_valid),
    .out_tag       (out_tag),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_jalr_done (out_jalr_done),
    .out_jalr_addr (out_jalr_addr)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush_in    = 1'b0;
    rdy_in      = 1'b1;
  endtask

  task automatic drive_issue(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [3:0] qj, input logic [3:0] qk, input logic rj, input logic rk,
                             input logic [31:0] addr, input logic len, input logic [3:0] dest);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
    issue_rj    = rj;
    issue_rk    = rk;
    issue_addr  = addr;
    issue_len   = len;
    issue_dest  = dest;
  endtask

  task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
  endtask

  task automatic flush_clean();
    idle();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle();
    drive_issue(OP_ADD, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    issue_valid = 1'b0;
    cdb_tag = 0;
    cdb_value = 0;
    step();
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result, out_zero, out_jalr_done, out_jalr_addr, rs_full} !== 72'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b tag=%0d res=%h full=%0b, expected all zero", out_valid, out_tag, out_result, rs_full);
    end
    rst_in = 1'b0;
    step();
    tests_run++;
    if ({out_valid, rs_full} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_release: got v=%0b full=%0b expected 0 0", out_valid, rs_full);
    end
  endtask

  task automatic test_add();
    flush_clean();
    drive_issue(OP_ADD, 5, 7, 0, 0, 1'b1, 1'b1, 32'h0, 1'b1, 3);
    step();
    idle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_early: out_valid=%0b expected 0", out_valid);
    end
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result, out_zero} !== {1'b1, 4'd3, 32'd12, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_result: got v=%0b tag=%0d res=%0d z=%0b expected 1 3 12 0", out_valid, out_tag, out_result, out_zero);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_single: out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_wakeup();
    flush_clean();
    drive_issue(OP_SUB, 0, 8, 6, 0, 1'b0, 1'b1, 0, 1'b1, 5);
    for (int c = 1; c <= 4; c++) begin
      step();
      idle();
      if (c == 1) drive_cdb(7, 99);
      if (c == 3) drive_cdb(6, 20);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL wakeup_wait c%0d: out_valid=%0b expected 0", c, out_valid);
      end
    end
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd5, 32'd12}) begin
      tests_failed++;
      $display("FAIL wakeup_result: got v=%0b tag=%0d res=%0d expected 1 5 12", out_valid, out_tag, out_result);
    end
    step();
    drive_issue(OP_SUB, 0, 8, 6, 0, 1'b0, 1'b1, 0, 1'b1, 5);
    drive_cdb(6, 20);
    step();
    idle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_early: out_valid=%0b expected 0", out_valid);
    end
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd5, 32'd12}) begin
      tests_failed++;
      $display("FAIL fwd_result: got v=%0b tag=%0d res=%0d expected 1 5 12", out_valid, out_tag, out_result);
    end
  endtask

  task automatic test_full_and_rotate();
    flush_clean();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rs_full !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_early i%0d: rs_full=%0b expected 0", i, rs_full);
      end
      drive_issue(OP_ADD, 0, i, 9, 0, 1'b0, 1'b1, 0, 1'b1, 4'(i + 1));
      step();
    end
    tests_run++;
    if (rs_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_set: rs_full=%0b expected 1", rs_full);
    end
    drive_issue(OP_ADD, 1, 1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 15);
    step();
    idle();
    drive_cdb(9, 100);
    step();
    idle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_wake_lat: out_valid=%0b expected 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if ({out_valid, out_tag, out_result} !== {1'b1, 4'(k + 1), 32'(100 + k)}) begin
        tests_failed++;
        $display("FAIL grant_order k%0d: got v=%0b tag=%0d res=%0d expected 1 %0d %0d", k, out_valid, out_tag, out_result, k + 1, 100 + k);
      end
      if (k == 0) begin
        tests_run++;
        if (rs_full !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_clear: rs_full=%0b expected 0", rs_full);
        end
      end
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fifth_ignored: out_valid=%0b tag=%0d expected 0", out_valid, out_tag);
    end
    for (int i = 0; i < 4; i++) begin
      drive_issue(OP_ADD, 0, i, (i % 2 == 0) ? 4'd10 : 4'd11, 0, 1'b0, 1'b1, 0, 1'b1, 4'(6 + i));
      step();
    end
    idle();
    tests_run++;
    if (rs_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL refill_full: rs_full=%0b expected 1", rs_full);
    end
    drive_cdb(10, 50);
    step();
    idle();
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd6, 32'd50}) begin
      tests_failed++;
      $display("FAIL refill_g0: got v=%0b tag=%0d res=%0d expected 1 6 50", out_valid, out_tag, out_result);
    end
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd8, 32'd52}) begin
      tests_failed++;
      $display("FAIL refill_g2: got v=%0b tag=%0d res=%0d expected 1 8 52", out_valid, out_tag, out_result);
    end
    drive_cdb(11, 70);
    step();
    idle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL refill_gap: out_valid=%0b expected 0", out_valid);
    end
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd9, 32'd73}) begin
      tests_failed++;
      $display("FAIL rotate_g3: got v=%0b tag=%0d res=%0d expected 1 9 73", out_valid, out_tag, out_result);
    end
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd7, 32'd71}) begin
      tests_failed++;
      $display("FAIL rotate_g1: got v=%0b tag=%0d res=%0d expected 1 7 71", out_valid, out_tag, out_result);
    end
  endtask

  task automatic test_jalr();
    flush_clean();
    drive_issue(OP_JALR, 32'h1001, 4, 0, 0, 1'b1, 1'b1, 32'h100, 1'b1, 2);
    step();
    idle();
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result, out_jalr_done, out_jalr_addr} !== {1'b1, 4'd2, 32'h104, 1'b1, 32'h1004}) begin
      tests_failed++;
      $display("FAIL jalr: got v=%0b tag=%0d res=%h jd=%0b ja=%h expected 1 2 104 1 1004", out_valid, out_tag, out_result, out_jalr_done, out_jalr_addr);
    end
  endtask

  task automatic test_back_to_back();
    flush_clean();
    drive_issue(OP_BEQ, 5, 5, 0, 0, 1'b1, 1'b1, 0, 1'b1, 3);
    step();
    drive_issue(OP_BNE, 5, 5, 0, 0, 1'b1, 1'b1, 0, 1'b1, 4);
    step();
    drive_issue(OP_ADD, 7, 32'hFFFF_FFF9, 0, 0, 1'b1, 1'b1, 0, 1'b1, 5);
    tests_run++;
    if ({out_valid, out_tag, out_zero} !== {1'b1, 4'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_beq: got v=%0b tag=%0d z=%0b expected 1 3 0", out_valid, out_tag, out_zero);
    end
    step();
    drive_issue(OP_JAL, 0, 0, 0, 0, 1'b1, 1'b1, 32'h200, 1'b0, 6);
    tests_run++;
    if ({out_valid, out_tag, out_zero} !== {1'b1, 4'd4, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_bne: got v=%0b tag=%0d z=%0b expected 1 4 1", out_valid, out_tag, out_zero);
    end
    step();
    idle();
    tests_run++;
    if ({out_valid, out_tag, out_result, out_zero} !== {1'b1, 4'd5, 32'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_add0: got v=%0b tag=%0d res=%0d z=%0b expected 1 5 0 1", out_valid, out_tag, out_result, out_zero);
    end
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd6, 32'h202}) begin
      tests_failed++;
      $display("FAIL b2b_jal16: got v=%0b tag=%0d res=%h expected 1 6 202", out_valid, out_tag, out_result);
    end
  endtask

  task automatic test_flush();
    flush_clean();
    for (int i = 0; i < 3; i++) begin
      drive_issue(OP_ADD, 0, 1, 12, 0, 1'b0, 1'b1, 0, 1'b1, 4'(1 + i));
      step();
    end
    idle();
    drive_cdb(12, 5);
    step();
    idle();
    flush_in = 1'b1;
    drive_issue(OP_ADD, 1, 1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 15);
    step();
    idle();
    tests_run++;
    if ({out_valid, rs_full} !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_now: got v=%0b full=%0b expected 0 0", out_valid, rs_full);
    end
    drive_cdb(12, 5);
    for (int c = 0; c < 4; c++) begin
      step();
      idle();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_after c%0d: out_valid=%0b tag=%0d expected 0", c, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_stall();
    flush_clean();
    drive_issue(OP_ADD, 3, 4, 0, 0, 1'b1, 1'b1, 0, 1'b1, 10);
    step();
    drive_issue(OP_SUB, 0, 1, 13, 0, 1'b0, 1'b1, 0, 1'b1, 11);
    step();
    idle();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd10, 32'd7}) begin
      tests_failed++;
      $display("FAIL stall_pre: got v=%0b tag=%0d res=%0d expected 1 10 7", out_valid, out_tag, out_result);
    end
    rdy_in = 1'b0;
    drive_cdb(13, 9);
    drive_issue(OP_ADD, 1, 1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 12);
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if ({out_valid, out_tag, out_result, rs_full} !== {1'b1, 4'd10, 32'd7, 1'b0}) begin
        tests_failed++;
        $display("FAIL stall_hold c%0d: got v=%0b tag=%0d res=%0d full=%0b expected 1 10 7 0", c, out_valid, out_tag, out_result, rs_full);
      end
    end
    idle();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_dropped: out_valid=%0b tag=%0d expected 0", out_valid, out_tag);
    end
    drive_cdb(13, 9);
    step();
    idle();
    step();
    tests_run++;
    if ({out_valid, out_tag, out_result} !== {1'b1, 4'd11, 32'd8}) begin
      tests_failed++;
      $display("FAIL stall_resume: got v=%0b tag=%0d res=%0d expected 1 11 8", out_valid, out_tag, out_result);
    end
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_no_issue: out_valid=%0b tag=%0d expected 0", out_valid, out_tag);
    end
  endtask

  task automatic test_reset_mid();
    flush_clean();
    drive_issue(OP_JALR, 32'h10, 0, 0, 0, 1'b1, 1'b1, 32'h40, 1'b1, 4);
    step();
    drive_issue(OP_ADD, 0, 1, 14, 0, 1'b0, 1'b1, 0, 1'b1, 5);
    step();
    idle();
    tests_run++;
    if ({out_valid, out_result, out_jalr_done, out_jalr_addr} !== {1'b1, 32'h44, 1'b1, 32'h10}) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got v=%0b res=%h jd=%0b ja=%h expected 1 44 1 10", out_valid, out_result, out_jalr_done, out_jalr_addr);
    end
    #2 rst_in = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, out_tag, out_result, out_zero, out_jalr_done, out_jalr_addr, rs_full} !== 72'd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got v=%0b tag=%0d res=%h jd=%0b ja=%h full=%0b expected all zero", out_valid, out_tag, out_result, out_jalr_done, out_jalr_addr, rs_full);
    end
    step();
    rst_in = 1'b0;
    drive_cdb(14, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      idle();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_cleared c%0d: out_valid=%0b tag=%0d expected 0", c, out_valid, out_tag);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_issue(OP_ADD, 0, 0, 15, 0, 1'b0, 1'b1, 0, 1'b1, 4'(i));
      step();
    end
    idle();
    tests_run++;
    if (rs_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstfull_pre: rs_full=%0b expected 1", rs_full);
    end
    #2 rst_in = 1'b1;
    #1;
    tests_run++;
    if (rs_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstfull_async: rs_full=%0b expected 0", rs_full);
    end
    step();
    rst_in = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_wakeup();
    test_full_and_rotate();
    test_jalr();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
